// File: rtl/aes_dec_round_ctrl.sv
// aes_dec_round_ctrl: iterative AES-128 decryption sequencer, one inverse round per cycle through an external datapath
module aes_dec_round_ctrl #(
  parameter int NR = 10,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          key_valid,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic [KW-1:0] rk_idx,
  input  logic [127:0]  rk_data,
  output logic [127:0]  dp_state,
  output logic          dp_last,
  input  logic [127:0]  dp_result,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} st_e;
  localparam logic [KW-1:0] NR_K = KW'(NR);
  st_e st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [KW-1:0] rnd_q, rnd_d;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q    <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end
  always_comb begin
    st_d      = st_q;
    state_d   = state_q;
    rnd_d     = rnd_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    dp_last   = 1'b0;
    rk_idx    = NR_K;
    dp_state  = state_q;
    case (st_q)
      IDLE: begin
        // in_ready is held low while reset is asserted even if key_valid is high
        in_ready = key_valid & resetn;
        if (in_valid && key_valid) begin
          state_d = in_data ^ rk_data;
          rnd_d   = NR_K - KW'(1);
          st_d    = ROUND;
        end
      end
      ROUND: begin
        busy    = 1'b1;
        rk_idx  = rnd_q;
        dp_last = (rnd_q == '0);
        state_d = dp_result;
        st_d    = (rnd_q == '0) ? DONE : ROUND;
        rnd_d   = (rnd_q == '0) ? rnd_q : rnd_q - KW'(1);
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = state_q;
        rk_idx    = '0;
        st_d      = out_ready ? IDLE : DONE;
      end
      default: st_d = IDLE;
    endcase
  end
endmodule
